// File: rtl/ahb_bridge_pkg.sv
// Shared AHB-Lite encodings and front-end state type for the AHB-to-APB bridge.
package ahb_bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WDAT = 3'd1,
    WAIT = 3'd2,
    ERR1 = 3'd3,
    ERR2 = 3'd4
  } state_e;

endpackage

// File: rtl/ahb_addr_decoder.sv
// Combinational region decoder: maps haddr/hsize onto a hit flag and a one-hot select.
module ahb_addr_decoder #(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter int          NUM_SLV     = 3,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          REGION_BITS = 26
) (
  input  logic [ADDR_W-1:0]  haddr,
  input  logic [2:0]         hsize,
  output logic               hit,
  output logic [NUM_SLV-1:0] sel
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [2:0]        MAX_SIZE = 3'($clog2(DATA_W / 8));

  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] idx;

  // Unsigned offset; addresses below BASE are rejected explicitly rather than wrapping.
  assign off = haddr - BASE;
  assign idx = off >> REGION_BITS;
  assign hit = (haddr >= BASE) && (idx < ADDR_W'(NUM_SLV)) && (hsize <= MAX_SIZE);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel[i] = hit && (idx == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/ahb_slave_if_gen.sv
// AHB-Lite slave front end: decodes NUM_SLV regions, registers one request at a
// time for the APB back end, and produces wait states, ERROR and timeout responses.
module ahb_slave_if_gen
  import ahb_bridge_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter int          NUM_SLV     = 3,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          REGION_BITS = 26,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic               hreadyin,
  input  logic [1:0]         htrans,
  input  logic               hwrite,
  input  logic [2:0]         hsize,
  input  logic [ADDR_W-1:0]  haddr,
  input  logic [DATA_W-1:0]  hwdata,
  output logic [DATA_W-1:0]  hrdata,
  output logic               hreadyout,
  output logic [1:0]         hresp,
  output logic               valid,
  output logic [NUM_SLV-1:0] selx,
  output logic [ADDR_W-1:0]  addr_q,
  output logic               write_q,
  output logic [2:0]         size_q,
  output logic [DATA_W-1:0]  wdata_q,
  input  logic [DATA_W-1:0]  rdata_in,
  input  logic               done_in
);

  localparam int                TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit                TO_EN   = (TIMEOUT_CYC > 0);
  localparam logic [TO_W-1:0]   TO_LAST = TO_EN ? TO_W'(TIMEOUT_CYC - 1) : '0;

  state_e            state, state_nxt;
  logic [TO_W-1:0]   to_cnt;
  logic              trans_active;
  logic              accept;
  logic              dec_hit;
  logic [NUM_SLV-1:0] dec_sel;

  ahb_addr_decoder #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .NUM_SLV     (NUM_SLV),
    .BASE_ADDR   (BASE_ADDR),
    .REGION_BITS (REGION_BITS)
  ) u_dec (
    .haddr (haddr),
    .hsize (hsize),
    .hit   (dec_hit),
    .sel   (dec_sel)
  );

  assign trans_active = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  assign accept       = hreadyin && trans_active && ((state == IDLE) || (state == ERR2));

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hreadyout = 1'b0;
    hresp     = HRESP_OKAY;
    valid     = 1'b0;
    unique case (state)
      IDLE: begin
        hreadyout = 1'b1;
      end
      WDAT: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        valid = 1'b1;
        // A completion in the terminal-count cycle takes priority over the timeout.
        if (done_in)                          state_nxt = IDLE;
        else if (TO_EN && (to_cnt == TO_LAST)) state_nxt = ERR1;
      end
      ERR1: begin
        hresp     = HRESP_ERROR;
        state_nxt = ERR2;
      end
      ERR2: begin
        hreadyout = 1'b1;
        hresp     = HRESP_ERROR;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (accept) begin
      if (!dec_hit)    state_nxt = ERR1;
      else if (hwrite) state_nxt = WDAT;
      else             state_nxt = WAIT;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      to_cnt <= '0;
    end else if ((state == WAIT) && (state_nxt == WAIT)) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  // Address phase capture: only hits update the request registers.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      selx    <= '0;
    end else if (accept && dec_hit) begin
      addr_q  <= haddr;
      write_q <= hwrite;
      size_q  <= hsize;
      selx    <= dec_sel;
    end
  end

  // Data phase capture: write data in WDAT, read data on back-end completion.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wdata_q <= '0;
      hrdata  <= '0;
    end else begin
      if (state == WDAT) wdata_q <= hwdata;
      if ((state == WAIT) && done_in && !write_q) hrdata <= rdata_in;
    end
  end

endmodule

// File: tb/tb_ahb_slave_if_gen.sv
// Directed bench for ahb_slave_if_gen with a 4-cycle completion timeout.
module tb_ahb_slave_if_gen;
  import ahb_bridge_pkg::*;

  logic        hclk;
  logic        hresetn;
  logic        hreadyin;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic        valid;
  logic [2:0]  selx;
  logic [31:0] addr_q;
  logic        write_q;
  logic [2:0]  size_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_in;
  logic        done_in;

  int npass  = 0;
  int ntotal = 0;

  ahb_slave_if_gen #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .NUM_SLV     (3),
    .BASE_ADDR   (32'h8000_0000),
    .REGION_BITS (26),
    .TIMEOUT_CYC (4)
  ) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hreadyin  (hreadyin),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .haddr     (haddr),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .valid     (valid),
    .selx      (selx),
    .addr_q    (addr_q),
    .write_q   (write_q),
    .size_q    (size_q),
    .wdata_q   (wdata_q),
    .rdata_in  (rdata_in),
    .done_in   (done_in)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic req(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                     input logic [31:0] a);
    htrans = tr;
    hwrite = wr;
    hsize  = sz;
    haddr  = a;
  endtask

  initial begin
    hresetn  = 1'b0;
    hreadyin = 1'b1;
    htrans   = HTRANS_IDLE;
    hwrite   = 1'b0;
    hsize    = 3'b010;
    haddr    = '0;
    hwdata   = '0;
    rdata_in = '0;
    done_in  = 1'b0;
    cyc();
    cyc();
    chk("rst_hreadyout", hreadyout, 1'b1);
    chk("rst_hresp", hresp, HRESP_OKAY);
    chk("rst_valid", valid, 1'b0);
    chk("rst_selx", selx, 3'b000);
    chk("rst_addr_q", addr_q, 32'h0);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_wdata_q", wdata_q, 32'h0);
    hresetn = 1'b1;
    cyc();

    // Read from region 1 with done_in in the first WAIT cycle
    req(HTRANS_NONSEQ, 1'b0, 3'b010, 32'h8400_0010);
    cyc();
    req(HTRANS_IDLE, 1'b0, 3'b010, 32'h0);
    chk("rd_t1_valid", valid, 1'b1);
    chk("rd_t1_hreadyout", hreadyout, 1'b0);
    chk("rd_t1_selx", selx, 3'b010);
    chk("rd_t1_addr_q", addr_q, 32'h8400_0010);
    chk("rd_t1_write_q", write_q, 1'b0);
    done_in  = 1'b1;
    rdata_in = 32'hDEAD_BEEF;
    cyc();
    done_in = 1'b0;
    chk("rd_t2_hreadyout", hreadyout, 1'b1);
    chk("rd_t2_hresp", hresp, HRESP_OKAY);
    chk("rd_t2_valid", valid, 1'b0);
    chk("rd_t2_hrdata", hrdata, 32'hDEAD_BEEF);

    // Write to region 2
    req(HTRANS_NONSEQ, 1'b1, 3'b010, 32'h8800_0004);
    cyc();
    req(HTRANS_IDLE, 1'b0, 3'b010, 32'h0);
    hwdata = 32'h1234_5678;
    chk("wr_t1_hreadyout", hreadyout, 1'b0);
    chk("wr_t1_valid", valid, 1'b0);
    chk("wr_t1_selx", selx, 3'b100);
    cyc();
    hwdata = 32'h0;
    chk("wr_t2_valid", valid, 1'b1);
    chk("wr_t2_wdata_q", wdata_q, 32'h1234_5678);
    chk("wr_t2_write_q", write_q, 1'b1);
    done_in  = 1'b1;
    rdata_in = 32'hFFFF_FFFF;
    cyc();
    done_in = 1'b0;
    chk("wr_t3_hreadyout", hreadyout, 1'b1);
    chk("wr_t3_hrdata_kept", hrdata, 32'hDEAD_BEEF);

    // Unmapped region index 3
    req(HTRANS_NONSEQ, 1'b0, 3'b010, 32'h8C00_0000);
    cyc();
    req(HTRANS_IDLE, 1'b0, 3'b010, 32'h0);
    chk("miss3_err1_hreadyout", hreadyout, 1'b0);
    chk("miss3_err1_hresp", hresp, HRESP_ERROR);
    chk("miss3_err1_valid", valid, 1'b0);
    chk("miss3_selx_kept", selx, 3'b100);
    cyc();
    chk("miss3_err2_hreadyout", hreadyout, 1'b1);
    chk("miss3_err2_hresp", hresp, HRESP_ERROR);
    chk("miss3_err2_valid", valid, 1'b0);
    cyc();
    chk("miss3_idle_hresp", hresp, HRESP_OKAY);

    // Below base address
    req(HTRANS_NONSEQ, 1'b0, 3'b010, 32'h7FFF_FFFC);
    cyc();
    req(HTRANS_IDLE, 1'b0, 3'b010, 32'h0);
    chk("below_err1_hreadyout", hreadyout, 1'b0);
    chk("below_err1_hresp", hresp, HRESP_ERROR);
    chk("below_err1_valid", valid, 1'b0);
    cyc();
    chk("below_err2_hreadyout", hreadyout, 1'b1);
    chk("below_err2_hresp", hresp, HRESP_ERROR);
    // SEQ read accepted in the ERR2 cycle
    req(HTRANS_SEQ, 1'b0, 3'b010, 32'h8000_0000);
    cyc();
    req(HTRANS_IDLE, 1'b0, 3'b010, 32'h0);
    chk("b2b_err2_valid", valid, 1'b1);
    chk("b2b_err2_selx", selx, 3'b001);
    chk("b2b_err2_addr_q", addr_q, 32'h8000_0000);
    done_in  = 1'b1;
    rdata_in = 32'h0BAD_F00D;
    cyc();
    done_in = 1'b0;
    chk("b2b_err2_hrdata", hrdata, 32'h0BAD_F00D);
    chk("b2b_err2_hreadyout", hreadyout, 1'b1);
    // SEQ read accepted in the IDLE completion cycle
    req(HTRANS_SEQ, 1'b0, 3'b001, 32'h8400_0040);
    cyc();
    req(HTRANS_IDLE, 1'b0, 3'b010, 32'h0);
    chk("b2b_idle_valid", valid, 1'b1);
    chk("b2b_idle_selx", selx, 3'b010);
    chk("b2b_idle_size_q", size_q, 3'b001);
    done_in  = 1'b1;
    rdata_in = 32'h5555_AAAA;
    cyc();
    done_in = 1'b0;
    chk("b2b_idle_hrdata", hrdata, 32'h5555_AAAA);

    // Oversized transfer (64-bit on a 32-bit bus)
    req(HTRANS_NONSEQ, 1'b0, 3'b011, 32'h8000_0008);
    cyc();
    req(HTRANS_IDLE, 1'b0, 3'b010, 32'h0);
    chk("size_err1_hreadyout", hreadyout, 1'b0);
    chk("size_err1_hresp", hresp, HRESP_ERROR);
    chk("size_err1_valid", valid, 1'b0);
    cyc();
    chk("size_err2_hreadyout", hreadyout, 1'b1);
    chk("size_err2_hresp", hresp, HRESP_ERROR);
    cyc();

    // Timeout with no completion: four WAIT cycles then ERROR
    req(HTRANS_NONSEQ, 1'b0, 3'b010, 32'h8000_0020);
    cyc();
    req(HTRANS_IDLE, 1'b0, 3'b010, 32'h0);
    cyc();
    cyc();
    cyc();
    chk("to_w4_valid", valid, 1'b1);
    cyc();
    chk("to_err1_valid", valid, 1'b0);
    chk("to_err1_hreadyout", hreadyout, 1'b0);
    chk("to_err1_hresp", hresp, HRESP_ERROR);
    done_in  = 1'b1;
    rdata_in = 32'h1111_2222;
    cyc();
    done_in = 1'b0;
    chk("to_err2_hresp", hresp, HRESP_ERROR);
    chk("to_err2_hreadyout", hreadyout, 1'b1);
    chk("to_late_done_ignored", hrdata, 32'h5555_AAAA);
    cyc();

    // Completion on the terminal-count cycle wins
    req(HTRANS_NONSEQ, 1'b0, 3'b010, 32'h8000_0024);
    cyc();
    req(HTRANS_IDLE, 1'b0, 3'b010, 32'h0);
    cyc();
    cyc();
    cyc();
    chk("tc_w4_valid", valid, 1'b1);
    done_in  = 1'b1;
    rdata_in = 32'hCAFE_F00D;
    cyc();
    done_in = 1'b0;
    chk("tc_hreadyout", hreadyout, 1'b1);
    chk("tc_hresp", hresp, HRESP_OKAY);
    chk("tc_hrdata", hrdata, 32'hCAFE_F00D);

    // Asynchronous reset in the middle of WAIT
    req(HTRANS_NONSEQ, 1'b0, 3'b010, 32'h8800_0000);
    cyc();
    req(HTRANS_IDLE, 1'b0, 3'b010, 32'h0);
    chk("mid_pre_valid", valid, 1'b1);
    hresetn = 1'b0;
    #1;
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_hreadyout", hreadyout, 1'b1);
    chk("mid_rst_selx", selx, 3'b000);
    chk("mid_rst_hrdata", hrdata, 32'h0);
    cyc();
    hresetn = 1'b1;
    cyc();
    chk("post_rst_hresp", hresp, HRESP_OKAY);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
